// File: rtl/xfm_rec_seq.sv
// xfm_rec_seq: time-multiplexed 4x4 inverse-Hadamard reconstruction, one component per output beat
module xfm_rec_seq #(
  parameter int NUM_COMP = 3,
  parameter int COEFF_SIZE = 9,
  parameter int BPC = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [7:0]                            m_qp,
  input  logic [NUM_COMP*16*COEFF_SIZE-1:0]     xfm_coeff,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(NUM_COMP>1?$clog2(NUM_COMP):1)-1:0] out_comp,
  output logic [16*(BPC+1)-1:0]                 out_rec
);
  localparam int CW = NUM_COMP > 1 ? $clog2(NUM_COMP) : 1;
  localparam int SW = BPC + 1;
  localparam int IW = $clog2(NUM_COMP*16*COEFF_SIZE);
  localparam logic signed [19:0] HB = 20'(2**(BPC-1));
  localparam logic signed [19:0] MX = 20'(2**BPC-1);
  localparam logic signed [19:0] MN = -20'(2**BPC);
  typedef enum logic [2:0] {IDLE, DEQ, ROW, COL, OUT} state_t;
  state_t state, state_n;
  logic [NUM_COMP*16*COEFF_SIZE-1:0] coeff_q;
  logic [6:0] qe_q;
  logic [CW-1:0] comp;
  logic [3:0] sft;
  logic [2:0] rm;
  logic [4:0] ls;
  logic signed [31:0] ls_s;
  logic last;
  logic signed [COEFF_SIZE-1:0] cf [16];
  logic signed [31:0] cx [16], p [16];
  logic signed [19:0] w [16], deq [16], row_y [16], z [16], v [16], u [16];
  logic [SW-1:0] rec_n [16];
  function automatic logic signed [19:0] bf(input logic signed [19:0] a, b, c, d, input int k);
    return k == 0 ? a + b + c + d : k == 1 ? a + b - c - d : k == 2 ? a - b - c + d : a - b + c - d;
  endfunction
  assign last = comp == CW'(NUM_COMP-1);
  assign in_ready = state == IDLE && !rst;
  assign out_comp = comp;
  assign sft = 4'(qe_q / 7'd6);
  assign rm = 3'(qe_q % 7'd6);
  assign ls = rm == 3'd0 ? 5'd16 : rm == 3'd1 ? 5'd18 : rm == 3'd2 ? 5'd20 : rm == 3'd3 ? 5'd23 : rm == 3'd4 ? 5'd25 : 5'd29;
  assign ls_s = $signed({27'd0, ls});
  // next-state: three compute cycles per component, then hold in OUT until accepted
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? DEQ : IDLE;
      DEQ: state_n = ROW;
      ROW: state_n = COL;
      COL: state_n = OUT;
      OUT: state_n = out_ready ? (last ? IDLE : DEQ) : OUT;
      default: state_n = IDLE;
    endcase
  end
  // state, registered out_valid and component counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      comp <= '0;
    end else begin
      state <= state_n;
      out_valid <= state_n == OUT;
      if (state == IDLE) comp <= '0;
      else if (state == OUT && out_ready) comp <= last ? '0 : comp + CW'(1);
    end
  end
  // dequantise current component with 16-bit saturation, row butterfly, column butterfly and clip
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cf[i] = coeff_q[IW'((int'(comp)*16 + i)*COEFF_SIZE) +: COEFF_SIZE];
      cx[i] = 32'(cf[i]);
      p[i] = (((cx[i] * ls_s) <<< sft) + 32'sd8) >>> 4;
      deq[i] = p[i] > 32'sd32767 ? 20'sd32767 : p[i] < -32'sd32768 ? -20'sd32768 : p[i][19:0];
    end
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) begin
        row_y[4*j+k] = bf(w[4*j], w[4*j+1], w[4*j+2], w[4*j+3], k);
        z[4*k+j] = bf(w[j], w[4+j], w[8+j], w[12+j], k);
      end
    for (int i = 0; i < 16; i++) begin
      v[i] = (z[i] + 20'sd8) >>> 4;
      u[i] = v[i] + HB;
      rec_n[i] = comp == '0 ? (u[i] < 20'sd0 ? '0 : u[i] > MX ? MX[SW-1:0] : u[i][SW-1:0])
                            : (v[i] < MN ? MN[SW-1:0] : v[i] > MX ? MX[SW-1:0] : v[i][SW-1:0]);
    end
  end
  // datapath: latch block on accept, single working array reused by DEQ and ROW, COL loads the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff_q <= '0;
      qe_q <= '0;
      out_rec <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        coeff_q <= xfm_coeff;
        qe_q <= m_qp > 8'd71 ? 7'd71 : m_qp[6:0];
      end
      for (int i = 0; i < 16; i++)
        if (state == DEQ) w[i] <= deq[i];
        else if (state == ROW) w[i] <= row_y[i];
      if (state == COL)
        for (int i = 0; i < 16; i++) out_rec[i*SW +: SW] <= rec_n[i];
    end
  end
endmodule

// File: doc/xfm_rec_seq.md
Name: xfm_rec_seq

Overview:
- Time-multiplexed 4x4 transform-mode reconstruction engine.
- Accepts one block of NUM_COMP x 16 quantised coefficients plus QP on a valid/ready handshake.
- Processes one component at a time: dequantise, 2D inverse Hadamard, round, offset/clip.
- Emits one reconstructed component per output beat to the reconstruction buffer. It replaces the fully parallel per-component reconstruction with a parametrised, back-pressurable engine.

Parameters:
- NUM_COMP, 3, number of colour components per block (1..4).
- COEFF_SIZE, 9, width of each signed input coefficient.
- BPC, 8, bits per component of reconstructed samples.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  coefficient block valid.
- in_ready  out  1  engine can accept a block.
- m_qp  in  8  quantisation parameter, sampled with the block.
- xfm_coeff  in  NUM_COMP*16*COEFF_SIZE  coefficients. Component c, index i=row*4+col, at bits [(c*16+i)*COEFF_SIZE +: COEFF_SIZE], signed.
- out_valid  out  1  reconstructed component valid.
- out_ready  in  1  downstream accepts.
- out_comp  out  max(1,$clog2(NUM_COMP))  component index of current beat.
- out_rec  out  16*(BPC+1)  sample i at [i*(BPC+1) +: BPC+1]. Component 0 is unsigned, zero-extended. Components >0 are signed.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, in_ready=0 while rst=1.
  - out_valid=0, out_comp=0, out_rec=0.
  - All internal registers cleared.
  - in_ready=1 from the first cycle after deassertion.
- FSM states: IDLE, DEQ, ROW, COL, OUT.
  - IDLE: in_ready=1. On in_valid in cycle T, latch coeffs and qp, set comp=0, go to DEQ.
  - DEQ -> ROW -> COL: one cycle each. COL registers final samples into out_rec.
  - OUT: out_valid=1, out_rec/out_comp stable until out_valid&out_ready.
    - On accept with comp<NUM_COMP-1: comp++, go to DEQ.
    - On accept of the last component: go to IDLE.
- Timing with out_ready tied high:
  - Component k is valid at cycle T+4+4k.
  - in_ready reasserts at T+4*NUM_COMP+1.
- in_ready=0 in every state except IDLE. No overlap between blocks.
- QP handling: qe = min(m_qp,71); s=qe/6; r=qe%6.
- Dequant:
  - LS[r] = {16,18,20,23,25,29}.
  - d = (c*LS[r]*2^s + 8) >>> 4 (arithmetic, floor).
  - d saturated to signed 16 bits [-32768, 32767].
- Row transform, per row x0..x3, applied to the dequantised block:
  - y0 = x0+x1+x2+x3
  - y1 = x0+x1-x2-x3
  - y2 = x0-x1-x2+x3
  - y3 = x0-x1+x2-x3
- Column transform: same butterfly on the row results. Internal width 20 bits signed, no overflow possible.
- Final scaling: v=(z+8)>>>4.
  - Component 0: v+2^(BPC-1), clipped to [0, 2^BPC-1].
  - Components >0: clipped to [-2^BPC, 2^BPC-1].
- out_valid is registered and never deasserts without a handshake.
- Inputs changing after acceptance have no effect.
- Reset during any state aborts the block immediately. No partial output is produced after reset release.

Test Plan:
1. DC, positive: qp=0, comp0 coeff0=16, all others 0, NUM_COMP=3 -> comp0 all 16 samples=129, comp1 all 0, comp2 all 0; out_comp sequence 0,1,2 at T+4, T+8, T+12.
2. DC, negative chroma: qp=0, comp1 coeff0=-16 -> comp1 all samples = -1 (0x1FF for BPC=8); comp0 all 128.
3. Clip and saturation:
   - qp=36, comp0 coeff0=255 -> comp0 all 255 (1148 clipped).
   - qp=71, comp1 coeff0=255 -> dequant saturates to 32767, comp1 all 255.
   - comp2 coeff0=-256, qp=71 -> comp2 all -256.
4. QP clamp: m_qp=200 gives output identical to m_qp=71 for random coefficients.
5. Backpressure: out_ready low 5 cycles during comp1 OUT -> out_rec/out_comp held stable, in_ready stays 0; second in_valid block not accepted until after the comp2 handshake.
6. Reset mid-operation: assert rst in ROW of comp1 -> out_valid=0 and out_rec=0 immediately; after release in_ready=1; a new block reconstructs correctly from comp0.
